sipo_deser: RTL and testbench

SIPO_DESER -- requirements
Module: sipo_deser

---
 rtl/sipo_deser_pkg.sv | 20 ++
 rtl/sipo_deser_bitcnt.sv | 40 ++++
 rtl/sipo_deser.sv | 161 ++++++++++++++++
 tb/tb_sipo_deser.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sipo_deser_pkg.sv
// sipo_deser_pkg: shared types and constants for the serial-to-parallel deserializer.
//   state_e        - deserializer FSM states
//   DEFAULT_WIDTH  - default frame width in bits
//   cnt_width()    - bit-counter width able to hold 0..width
package sipo_deser_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        HOLD  = 2'd3
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_deser_bitcnt.sv
// sipo_deser_bitcnt: per-frame bit counter.
//   clk, rst - clock, asynchronous active-low reset
//   clr      - return count to 0 (highest priority)
//   load     - count := 1 (first bit of a frame sampled)
//   inc      - count := count + 1
//   tc_c     - combinational: the bit sampled on this edge is bit WIDTH
module sipo_deser_bitcnt
    import sipo_deser_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  logic inc,
    output logic tc_c
);

    localparam int unsigned CW = cnt_width(WIDTH);

    logic [CW-1:0] count;

    // Counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(1);
        end else if (inc) begin
            count <= count + CW'(1);
        end
    end

    // WIDTH-1 bits already held, so the current sample completes the frame
    assign tc_c = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: MSB-first serial-in, parallel-out deserializer with valid/ready output.
//   clk, rst     - clock, asynchronous active-low reset
//   d, d_en      - serial data bit and its sample enable
//   start        - sampled bit is first bit of a frame (only with d_en)
//   dout         - assembled word, dout_valid marks a complete frame
//   dout_ready   - consumer accept, handshake on dout_valid && dout_ready
//   overrun      - one-cycle pulse when a frame start is dropped in HOLD
//   parity_err   - even-parity check result, valid with dout_valid
// Build option: SIPO_DESER_PARITY_EN adds a trailing even-parity bit per frame;
// without it parity_err is tied low.
module sipo_deser
    import sipo_deser_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             d_en,
    input  logic             start,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    output logic             parity_err
);

    state_e           state, state_d;
    logic [WIDTH-2:0] shreg, shreg_d;
    logic [WIDTH-1:0] dout_d;
    logic             valid_d;
    logic             ovr_d;
    logic             cnt_clr, cnt_load, cnt_inc;
    logic             tc_c;
    logic             first_c;
    logic [WIDTH-1:0] shifted_c;

`ifdef SIPO_DESER_PARITY_EN
    logic parity_q, perr_d;
`endif

    sipo_deser_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .load (cnt_load),
        .inc  (cnt_inc),
        .tc_c (tc_c)
    );

    assign first_c   = start && d_en;
    assign shifted_c = {shreg, d};

    // Next-state and next-output logic
    always_comb begin
        state_d  = state;
        shreg_d  = shreg;
        dout_d   = dout;
        valid_d  = dout_valid;
        ovr_d    = 1'b0;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
`ifdef SIPO_DESER_PARITY_EN
        perr_d   = parity_q;
`endif
        case (state)
            IDLE: begin
                if (first_c) begin
                    shreg_d  = (WIDTH-1)'(d);
                    cnt_load = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (first_c) begin
                    shreg_d  = (WIDTH-1)'(d);
                    cnt_load = 1'b1;
                end else if (d_en) begin
                    shreg_d = shifted_c[WIDTH-2:0];
                    if (tc_c) begin
                        dout_d  = shifted_c;
                        cnt_clr = 1'b1;
`ifdef SIPO_DESER_PARITY_EN
                        state_d = PAR;
`else
                        valid_d = 1'b1;
                        state_d = HOLD;
`endif
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
`ifdef SIPO_DESER_PARITY_EN
            PAR: begin
                if (first_c) begin
                    shreg_d  = (WIDTH-1)'(d);
                    cnt_load = 1'b1;
                    state_d  = SHIFT;
                end else if (d_en) begin
                    valid_d = 1'b1;
                    perr_d  = ^{dout, d};
                    state_d = HOLD;
                end
            end
`endif
            HOLD: begin
                // dout_valid is always 1 here, so ready alone completes the handshake
                if (dout_ready) begin
                    valid_d = 1'b0;
                    if (first_c) begin
                        shreg_d  = (WIDTH-1)'(d);
                        cnt_load = 1'b1;
                        state_d  = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (first_c) begin
                    ovr_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_d;
            shreg      <= shreg_d;
            dout       <= dout_d;
            dout_valid <= valid_d;
            overrun    <= ovr_d;
        end
    end

`ifdef SIPO_DESER_PARITY_EN
    // Parity result register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= perr_d;
        end
    end

    assign parity_err = parity_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: directed bench for sipo_deser (WIDTH=8) with a frame-level
// reference model and per-cycle output comparison.
module tb_sipo_deser;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         d = 1'b0;
    logic         d_en = 1'b0;
    logic         start = 1'b0;
    logic         dout_ready = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         overrun;
    logic         parity_err;

    int checks = 0;
    int errors = 0;

    sipo_deser #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .d_en       (d_en),
        .start      (start),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

`ifdef SIPO_DESER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    // Reference model: collects bits as a number, frames as held words
    int           m_n;
    int unsigned  m_acc;
    logic [W-1:0] m_dout;
    logic         m_valid, m_ovr, m_perr, m_hold, m_par;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_n = 0; m_acc = 0; m_dout = '0; m_valid = 0;
            m_ovr = 0; m_perr = 0; m_hold = 0; m_par = 0;
        end else begin
            m_ovr = 0;
            if (m_hold) begin
                if (dout_ready) begin
                    m_hold = 0; m_valid = 0;
                    if (d_en && start) begin m_acc = 32'(d); m_n = 1; end
                end else if (d_en && start) begin
                    m_ovr = 1;
                end
            end else if (m_par) begin
                if (d_en) begin
                    m_par = 0;
                    if (start) begin
                        m_acc = 32'(d); m_n = 1;
                    end else begin
                        m_hold = 1; m_valid = 1;
                        m_perr = (($countones(m_dout) + int'(d)) % 2) == 1;
                    end
                end
            end else if (d_en) begin
                if (start) begin
                    m_acc = 32'(d); m_n = 1;
                end else if (m_n > 0) begin
                    m_acc = m_acc * 2 + 32'(d); m_n++;
                end
                if (m_n == int'(W)) begin
                    m_dout = W'(m_acc); m_n = 0; m_acc = 0;
                    if (PAR_EN) m_par = 1;
                    else begin m_hold = 1; m_valid = 1; end
                end
            end
        end
    end

    task automatic cmp1(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        cmp1("dout_valid", 32'(dout_valid), 32'(m_valid));
        cmp1("overrun", 32'(overrun), 32'(m_ovr));
        if (m_valid || !rst) cmp1("dout", 32'(dout), 32'(m_dout));
        if (m_valid || !rst || !PAR_EN) cmp1("parity_err", 32'(parity_err), 32'(m_perr));
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic put(input logic den, input logic dd, input logic st, input logic rdy);
        d_en = den; d = dd; start = st; dout_ready = rdy;
        tick();
    endtask

    // Sends one frame MSB first; gapped mode inserts d_en=0 cycles carrying start=1 noise
    task automatic send_frame(input logic [W-1:0] w, input bit gapped, input logic rdy, input logic pbit);
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (gapped && i != int'(W) - 1)
                for (int g = 0; g < (i % 3) + 1; g++) put(1'b0, ~w[i], 1'b1, rdy);
            put(1'b1, w[i], i == int'(W) - 1, rdy);
        end
`ifdef SIPO_DESER_PARITY_EN
        put(1'b1, pbit, 1'b0, rdy);
`else
        if (pbit) put(1'b0, 1'b0, 1'b0, rdy);
`endif
    endtask

    initial begin
        repeat (3) tick();
        cmp1("rst_dout", 32'(dout), 32'h0);
        cmp1("rst_valid", 32'(dout_valid), 32'h0);
        cmp1("rst_overrun", 32'(overrun), 32'h0);
        rst = 1'b1;
        put(0, 0, 0, 0);
        // bits without a start are ignored
        repeat (3) put(1, 1, 0, 0);
        cmp1("nostart_valid", 32'(dout_valid), 32'h0);

        // back-to-back frame, consumer always ready
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        cmp1("a5_valid", 32'(dout_valid), 32'h1);
        cmp1("a5_dout", 32'(dout), 32'hA5);
        put(0, 0, 0, 1);
        cmp1("a5_valid_one_cycle", 32'(dout_valid), 32'h0);

        // gapped frame, consumer stalls
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            put(0, 0, 0, 0);
            cmp1("3c_hold_valid", 32'(dout_valid), 32'h1);
            cmp1("3c_hold_dout", 32'(dout), 32'h3C);
        end
        put(0, 0, 0, 1);
        cmp1("3c_released", 32'(dout_valid), 32'h0);

        // dropped start in HOLD, then start coinciding with ready
        send_frame(8'h96, 1'b0, 1'b0, 1'b0);
        put(1, 1, 1, 0);
        cmp1("ovr_pulse", 32'(overrun), 32'h1);
        cmp1("ovr_dout", 32'(dout), 32'h96);
        put(0, 0, 0, 0);
        cmp1("ovr_end", 32'(overrun), 32'h0);
        send_frame(8'h0F, 1'b0, 1'b1, 1'b0);
        cmp1("0f_dout", 32'(dout), 32'h0F);
        cmp1("0f_valid", 32'(dout_valid), 32'h1);
        put(0, 0, 0, 1);

        // restart after 3 bits
        put(1, 1, 1, 0); put(1, 0, 0, 0); put(1, 1, 0, 0);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0);
        cmp1("c3_dout", 32'(dout), 32'hC3);
        cmp1("c3_valid", 32'(dout_valid), 32'h1);
        put(0, 0, 0, 1);

        // reset mid-frame
        put(1, 1, 1, 0);
        repeat (4) put(1, 1, 0, 0);
        #2 rst = 1'b0;
        #1;
        cmp1("midrst_valid", 32'(dout_valid), 32'h0);
        cmp1("midrst_dout", 32'(dout), 32'h0);
        compare_all();
        tick();
        rst = 1'b1;
        repeat (5) put(1, 1, 0, 0);
        cmp1("midrst_no_stale", 32'(dout_valid), 32'h0);

        // reset while holding a frame
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        cmp1("holdrst_valid", 32'(dout_valid), 32'h0);
        tick();
        rst = 1'b1;
        repeat (2) put(0, 0, 0, 1);

`ifdef SIPO_DESER_PARITY_EN
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        cmp1("par_ok", 32'(parity_err), 32'h0);
        cmp1("par_ok_valid", 32'(dout_valid), 32'h1);
        put(0, 0, 0, 1);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        cmp1("par_bad", 32'(parity_err), 32'h1);
        put(0, 0, 0, 1);
`else
        send_frame(8'hFE, 1'b0, 1'b0, 1'b0);
        cmp1("noparity_err", 32'(parity_err), 32'h0);
        put(0, 0, 0, 1);
`endif
        repeat (2) put(0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
